// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM encoding, NOP constant, IF/ID payload.
package pc_fetch_unit_pkg;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

  // addi x0,x0,0 -- also used by the hazard unit for its bubbles
  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: hold, bubble insert or load of the fetched instruction.
module if_id_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = FETCH_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst,
  output if_id_t      q
);

  // Hold wins over bubble; a bubble still records the fetch PC for debug visibility.
  always_ff @(posedge clk) begin
    if (reset) begin
      q.pc    <= 32'h0;
      q.inst  <= NOP_INST;
      q.valid <= 1'b0;
    end else if (!hold) begin
      q.pc <= fetch_pc;
      if (bubble) begin
        q.inst  <= NOP_INST;
        q.valid <= 1'b0;
      end else begin
        q.inst  <= fetch_inst;
        q.valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage fetch controller: PC register, IF/ID register, mispredict redirect,
// stall and halt handling. Optional statistics counters under PC_FETCH_STATS_EN.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = FETCH_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_stall,
  input  logic [31:0] predicted_pc,
  input  logic [31:0] imem_dout,
  input  logic        ID_branch,
  input  logic        ID_is_halt,
  input  logic [31:0] ID_next_pc,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_valid,
  output logic        mispredict,
  output logic        halted
`ifdef PC_FETCH_STATS_EN
  ,
  output logic [31:0] stat_branch_cnt,
  output logic [31:0] stat_mispred_cnt
`endif
);

  fetch_state_e state, state_nxt;
  if_id_t       if_id_q;
  logic         run;
  logic         halt_take;

  assign run = (state == FETCH_RUN);

  // A bubble in ID never halts or redirects; a stall defers both.
  assign halt_take  = run && !is_stall && if_id_q.valid && ID_is_halt;
  assign mispredict = run && !is_stall && if_id_q.valid && !ID_is_halt &&
                      (ID_next_pc != IF_pc);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH_RUN;
    else       state <= state_nxt;
  end

  // FSM next state: HALTED is sticky until reset
  always_comb begin
    state_nxt = state;
    if (halt_take) state_nxt = FETCH_HALTED;
  end

  // FSM outputs
  always_comb begin
    halted = (state == FETCH_HALTED);
  end

  // PC register: hold on halt/stall, redirect on mispredict, else follow predictor
  always_ff @(posedge clk) begin
    if (reset)                           IF_pc <= RESET_PC;
    else if (!run || is_stall || halt_take) IF_pc <= IF_pc;
    else if (mispredict)                 IF_pc <= ID_next_pc;
    else                                 IF_pc <= predicted_pc;
  end

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .hold       (!run || is_stall),
    .bubble     (halt_take || mispredict),
    .fetch_pc   (IF_pc),
    .fetch_inst (imem_dout),
    .q          (if_id_q)
  );

  assign IF_ID_pc    = if_id_q.pc;
  assign IF_ID_inst  = if_id_q.inst;
  assign IF_ID_valid = if_id_q.valid;

`ifdef PC_FETCH_STATS_EN
  // Branch and redirect counters, free-running modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branch_cnt  <= 32'h0;
      stat_mispred_cnt <= 32'h0;
    end else begin
      if (ID_branch && if_id_q.valid && !is_stall && run && !ID_is_halt)
        stat_branch_cnt <= stat_branch_cnt + 32'h1;
      if (mispredict)
        stat_mispred_cnt <= stat_mispred_cnt + 32'h1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = ID_branch;
`endif

endmodule
